fetch_queue: RTL and testbench



---
 rtl/cpu_pkg.sv | 17 +
 rtl/fq_ctrl.sv | 71 +++++++
 rtl/fetch_queue.sv | 72 +++++++
 tb/tb_fetch_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU widths, the fetch entry type and a parameter-check helper
package cpu_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_ILEN = 32;

    // Entry handed from fetch to decode at the default core widths.
    typedef struct packed {
        logic [DEF_XLEN-1:0] pc;
        logic [DEF_ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic bit is_pow2(input int n);
        return n > 0 && (n & (n - 1)) == 0;
    endfunction

endpackage

// File: rtl/fq_ctrl.sv
// fq_ctrl: pointer/occupancy bookkeeping and push/pop/flush priority for fetch_queue
//   in : clk, rst, flush, push_valid, pop_ready
//   out: push_ready, pop_valid, wr_en (storage write strobe), wr_ptr, rd_ptr,
//        count, full, empty
module fq_ctrl
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push_valid,
    input  logic          pop_ready,
    output logic          push_ready,
    output logic          pop_valid,
    output logic          wr_en,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("fetch_queue DEPTH must be a power of two and at least 2");
    end

    logic          push_fire;
    logic          pop_fire;
    logic [PW-1:0] wr_nxt;
    logic [PW-1:0] rd_nxt;
    logic [CW-1:0] cnt_nxt;

    always_comb begin
        full       = count == CW'(DEPTH);
        empty      = count == '0;
        push_ready = !full;
        pop_valid  = !empty;
        push_fire  = push_valid && push_ready;
        pop_fire   = pop_valid && pop_ready;
        // A push in a flush cycle belongs to the wrong path, so it never reaches storage.
        wr_en      = push_fire && !flush && !rst;
        wr_nxt     = flush ? '0 : wr_ptr + PW'(push_fire);
        rd_nxt     = flush ? '0 : rd_ptr + PW'(pop_fire);
        cnt_nxt    = flush ? '0 : count + CW'(push_fire) - CW'(pop_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_nxt;
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
        end
    end

    // Underflow wraps the unsigned count above DEPTH, so one bound covers both directions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count <= CW'(DEPTH));
            assert (PW'(wr_ptr - rd_ptr) == PW'(count));
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry first-word-fall-through (pc, instr) buffer between fetch and decode
//   in : clk, rst, flush, push_valid, push_pc, push_instr, pop_ready
//   out: push_ready, pop_valid, pop_pc, pop_instr, count, full, empty
module fetch_queue
    import cpu_pkg::*;
#(
    parameter  int XLEN  = DEF_XLEN,
    parameter  int ILEN  = DEF_ILEN,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push_valid,
    output logic            push_ready,
    input  logic [XLEN-1:0] push_pc,
    input  logic [ILEN-1:0] push_instr,
    output logic            pop_valid,
    input  logic            pop_ready,
    output logic [XLEN-1:0] pop_pc,
    output logic [ILEN-1:0] pop_instr,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);

    localparam int PW = $clog2(DEPTH);

    // Same layout as fetch_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic          wr_en;
    logic          rst_q;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    fq_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .pop_ready  (pop_ready),
        .push_ready (push_ready),
        .pop_valid  (pop_valid),
        .wr_en      (wr_en),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (wr_en)
            mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
    end

    // Storage is never cleared, so the head is forced to zero until reset has settled.
    always_comb begin
        head      = mem[rd_ptr];
        pop_pc    = (rst || rst_q) ? '0 : head.pc;
        pop_instr = (rst || rst_q) ? '0 : head.instr;
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: vector table plus scoreboard checks of fetch_queue at DEPTH 4, 2 and 16
module tb_fetch_queue;

    logic        clk = 0;
    logic        rst, flush, push_valid, pop_ready;
    logic        push_ready, pop_valid, full, empty;
    logic [31:0] push_pc, push_instr, pop_pc, pop_instr;
    logic [2:0]  count;
    logic [63:0] q[$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    fetch_queue #(.XLEN(32), .ILEN(32), .DEPTH(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_pc    (push_pc),
        .push_instr (push_instr),
        .pop_valid  (pop_valid),
        .pop_ready  (pop_ready),
        .pop_pc     (pop_pc),
        .pop_instr  (pop_instr),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One clock of the DEPTH=4 instance against the reference queue q.
    task automatic cyc();
        logic pf;
        #1;
        if (rst) q.delete();
        else begin
            chk("pop_valid", pop_valid, q.size() != 0);
            chk("push_ready", push_ready, q.size() < 4);
            pf = push_valid && q.size() < 4;
            if (pop_ready && q.size() != 0) chk("pop_data", {pop_pc, pop_instr}, q.pop_front());
            if (flush) q.delete();
            else if (pf) q.push_back({push_pc, push_instr});
        end
        @(posedge clk);
        #1;
        chk("count", count, q.size());
    endtask

    typedef struct {
        logic        pv;
        logic [31:0] pc;
        logic        pr;
        logic        fl;
        int          cnt;
        logic        fu;
        logic        em;
    } vec_t;

    vec_t vt[15];

    for (genvar g = 0; g < 2; g++) begin : sw
        localparam int D = g == 0 ? 2 : 16;
        localparam int C = $clog2(D + 1);
        logic         r, fl, pv, pr, prdy, pvld, fu, em;
        logic         done = 0;
        logic [63:0]  ppc, opc;
        logic [31:0]  pin, oin;
        logic [C-1:0] cnt;

        fetch_queue #(.XLEN(64), .ILEN(32), .DEPTH(D)) u (
            .clk        (clk),
            .rst        (r),
            .flush      (fl),
            .push_valid (pv),
            .push_ready (prdy),
            .push_pc    (ppc),
            .push_instr (pin),
            .pop_valid  (pvld),
            .pop_ready  (pr),
            .pop_pc     (opc),
            .pop_instr  (oin),
            .count      (cnt),
            .full       (fu),
            .empty      (em)
        );

        initial begin
            logic [95:0] sq[$];
            logic        pf;
            r = 1; fl = 0; pv = 0; pr = 0; ppc = 0; pin = 0;
            repeat (2) @(posedge clk);
            #1;
            r = 0;
            for (int i = 0; i < 1000; i++) begin
                pv  = ($urandom % 4) != 0;
                pr  = ($urandom % 3) != 0;
                fl  = ($urandom % 64) == 0;
                ppc = {$urandom, $urandom};
                pin = $urandom;
                #1;
                chk($sformatf("d%0d_pop_valid", D), pvld, sq.size() != 0);
                chk($sformatf("d%0d_full", D), fu, sq.size() == D);
                pf = pv && sq.size() < D;
                if (pr && sq.size() != 0) chk($sformatf("d%0d_pop_data", D), {opc, oin}, sq.pop_front());
                if (fl) sq.delete();
                else if (pf) sq.push_back({ppc, pin});
                @(posedge clk);
                #1;
                chk($sformatf("d%0d_count", D), cnt, sq.size());
            end
            pv = 0; pr = 0; fl = 0;
            done = 1;
        end
    end

    initial begin
        for (int i = 0; i < 4; i++)
            vt[i] = '{pv: 1, pc: 32'(4 * i), pr: 0, fl: 0, cnt: i + 1, fu: logic'(i == 3), em: 0};
        vt[4] = '{pv: 1, pc: 32'h10, pr: 0, fl: 0, cnt: 4, fu: 1, em: 0};
        for (int i = 5; i < 9; i++)
            vt[i] = '{pv: 0, pc: 0, pr: 1, fl: 0, cnt: 8 - i, fu: 0, em: logic'(i == 8)};
        for (int i = 9; i < 12; i++)
            vt[i] = '{pv: 1, pc: 32'(32'h20 + 4 * (i - 9)), pr: 0, fl: 0, cnt: i - 8, fu: 0, em: 0};
        vt[12] = '{pv: 1, pc: 32'h100, pr: 0, fl: 1, cnt: 0, fu: 0, em: 1};
        vt[13] = '{pv: 1, pc: 32'h200, pr: 0, fl: 0, cnt: 1, fu: 0, em: 0};
        vt[14] = '{pv: 0, pc: 0, pr: 1, fl: 0, cnt: 0, fu: 0, em: 1};

        rst = 1; flush = 0; push_valid = 0; pop_ready = 0; push_pc = 0; push_instr = 0;
        repeat (2) begin
            cyc();
            chk("rst_pop_pc", pop_pc, 0);
        end
        rst = 0;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_push_ready", push_ready, 1);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_count", count, 0);

        for (int i = 0; i < 15; i++) begin
            push_valid = vt[i].pv;
            push_pc    = vt[i].pc;
            push_instr = 32'h13 + 32'(i);
            pop_ready  = vt[i].pr;
            flush      = vt[i].fl;
            cyc();
            chk($sformatf("vec%0d_count", i), count, vt[i].cnt);
            chk($sformatf("vec%0d_full", i), full, vt[i].fu);
            chk($sformatf("vec%0d_empty", i), empty, vt[i].em);
            chk($sformatf("vec%0d_pop_valid", i), pop_valid, !vt[i].em);
            if (i == 13) chk("flush_head_pc", pop_pc, 32'h200);
        end

        push_valid = 1; pop_ready = 0; flush = 0;
        for (int k = 0; k < 12; k++) begin
            push_pc    = 32'h300 + 32'(4 * k);
            push_instr = 32'h1000 + 32'(k);
            pop_ready  = k >= 2;
            cyc();
            if (k >= 2) chk("wrap_count", count, 2);
        end
        push_valid = 0; pop_ready = 1;
        repeat (2) cyc();
        chk("wrap_drained", empty, 1);

        pop_ready = 0;
        for (int k = 0; k < 200 && count != 3; k++) begin
            push_valid = ($urandom % 4) != 0;
            pop_ready  = ($urandom % 4) == 0;
            push_pc    = $urandom;
            push_instr = $urandom;
            cyc();
        end
        chk("burst_reached_3", count, 3);
        rst = 1; push_valid = 1; flush = 1; pop_ready = 1;
        cyc();
        rst = 0; push_valid = 0; flush = 0; pop_ready = 0;
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_pop_pc", pop_pc, 0);
        chk("midrst_pop_instr", pop_instr, 0);
        for (int k = 0; k < 60; k++) begin
            push_valid = ($urandom % 3) != 0;
            pop_ready  = ($urandom % 2) != 0;
            flush      = ($urandom % 32) == 0;
            push_pc    = $urandom;
            push_instr = $urandom;
            cyc();
        end
        push_valid = 0; flush = 0; pop_ready = 1;
        repeat (5) cyc();
        chk("final_empty", empty, 1);

        fork
            wait (sw[0].done && sw[1].done);
            repeat (3000) @(posedge clk);
        join_any
        disable fork;
        chk("sweep_done", {sw[0].done, sw[1].done}, 2'b11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
